// File: rtl/cyq_seg_scan_ctrl.sv
// cyq_seg_scan_ctrl: 4-digit multiplexed seven-segment scan controller.
// It drives active-low digit commons and active-high segments (a..g), blanks
// the start of every digit slot, and double-buffers new display contents so
// they only take effect at a frame boundary.
module cyq_seg_scan_ctrl #(
  parameter int DIV   = 4,  // clock cycles per digit slot (2..65535)
  parameter int BLANK = 1   // blanking cycles at slot start (0..DIV-1)
) (
  input  logic        Clk,
  input  logic        Aclr,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  mask,
  output logic        pending,
  output logic        frame_start,
  output logic        COM_1,
  output logic        COM_2,
  output logic        COM_3,
  output logic        COM_4,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [15:0]   sh_digits_q, sh_digits_d;
  logic [3:0]    sh_mask_q, sh_mask_d;
  logic [15:0]   act_digits_q, act_digits_d;
  logic [3:0]    act_mask_q, act_mask_d;
  logic          pending_q, pending_d;
  logic          frame_start_q, frame_start_d;
  logic [3:0]    com_q, com_d;
  logic [6:0]    seg_q, seg_d;
  logic          in_blank_d;

  // Segment pattern {a,b,c,d,e,f,g} for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Next-state for prescaler, slot counter, and the shadow/active buffers.
  always_comb begin
    logic cnt_wrap;
    logic frame_wrap;
    cnt_wrap      = (cnt_q == CNT_MAX);
    frame_wrap    = cnt_wrap && (slot_q == 2'd3);
    cnt_d         = cnt_wrap ? '0 : cnt_q + 1'b1;
    slot_d        = cnt_wrap ? slot_q + 2'd1 : slot_q;
    sh_digits_d   = sh_digits_q;
    sh_mask_d     = sh_mask_q;
    act_digits_d  = act_digits_q;
    act_mask_d    = act_mask_q;
    pending_d     = pending_q;
    frame_start_d = frame_wrap;
    if (load) begin
      sh_digits_d = digits;
      sh_mask_d   = mask;
    end
    if (frame_wrap) begin
      // A load landing on the wrap edge skips the shadow entirely.
      if (load) begin
        act_digits_d = digits;
        act_mask_d   = mask;
      end else if (pending_q) begin
        act_digits_d = sh_digits_q;
        act_mask_d   = sh_mask_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Blanking window: with no blanking the comparison would be vacuous.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank_d = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
      assign in_blank_d = (cnt_d < BLANK_C);
    end
  endgenerate

  // Output decode from next-state values so COM and segments register together.
  always_comb begin
    logic       lit;
    logic [3:0] nib;
    nib   = act_digits_d[{slot_d, 2'b00} +: 4];
    lit   = !in_blank_d && !act_mask_d[slot_d];
    com_d = 4'b1111;
    seg_d = 7'd0;
    if (lit) begin
      com_d = ~(4'b0001 << slot_d);
      seg_d = seg_decode(nib);
    end
  end

  // State and output registers; reset leaves the display dark and fully masked.
  always_ff @(posedge Clk or posedge Aclr) begin
    if (Aclr) begin
      cnt_q         <= '0;
      slot_q        <= 2'd0;
      sh_digits_q   <= 16'd0;
      sh_mask_q     <= 4'b1111;
      act_digits_q  <= 16'd0;
      act_mask_q    <= 4'b1111;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      com_q         <= 4'b1111;
      seg_q         <= 7'd0;
    end else begin
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      sh_digits_q   <= sh_digits_d;
      sh_mask_q     <= sh_mask_d;
      act_digits_q  <= act_digits_d;
      act_mask_q    <= act_mask_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      com_q         <= com_d;
      seg_q         <= seg_d;
    end
  end

  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign COM_1       = com_q[0];
  assign COM_2       = com_q[1];
  assign COM_3       = com_q[2];
  assign COM_4       = com_q[3];
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_cyq_seg_scan_ctrl.sv
// Directed bench for cyq_seg_scan_ctrl: main instance DIV=4/BLANK=1 plus
// three parameter-sweep instances sharing clock and reset.
module tb_cyq_seg_scan_ctrl;

  logic        Clk = 1'b0;
  logic        Aclr = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits = 16'd0;
  logic [3:0]  mask = 4'd0;
  logic        load_s = 1'b0;
  logic [15:0] dig_s = 16'h8888;
  logic [3:0]  mask_s = 4'd0;

  logic pending, frame_start, c1, c2, c3, c4, sa, sb, sc, sd, se, sf, sg;
  logic [3:0] com0;
  logic [6:0] seg0;
  assign com0 = {c4, c3, c2, c1};
  assign seg0 = {sa, sb, sc, sd, se, sf, sg};

  logic [3:0] comA, comB, comC;
  logic [6:0] segA, segB, segC;
  logic pA, pB, pC, fA, fB, fC;

  int n_assert = 0;
  int n_fail = 0;
  int n = 0;

  always #5 Clk = ~Clk;

  cyq_seg_scan_ctrl #(.DIV(4), .BLANK(1)) u_dut (
    .Clk(Clk), .Aclr(Aclr), .load(load), .digits(digits), .mask(mask),
    .pending(pending), .frame_start(frame_start),
    .COM_1(c1), .COM_2(c2), .COM_3(c3), .COM_4(c4),
    .a(sa), .b(sb), .c(sc), .d(sd), .e(se), .f(sf), .g(sg));

  cyq_seg_scan_ctrl #(.DIV(2), .BLANK(0)) u_swa (
    .Clk(Clk), .Aclr(Aclr), .load(load_s), .digits(dig_s), .mask(mask_s),
    .pending(pA), .frame_start(fA),
    .COM_1(comA[0]), .COM_2(comA[1]), .COM_3(comA[2]), .COM_4(comA[3]),
    .a(segA[6]), .b(segA[5]), .c(segA[4]), .d(segA[3]), .e(segA[2]), .f(segA[1]), .g(segA[0]));

  cyq_seg_scan_ctrl #(.DIV(2), .BLANK(1)) u_swb (
    .Clk(Clk), .Aclr(Aclr), .load(load_s), .digits(dig_s), .mask(mask_s),
    .pending(pB), .frame_start(fB),
    .COM_1(comB[0]), .COM_2(comB[1]), .COM_3(comB[2]), .COM_4(comB[3]),
    .a(segB[6]), .b(segB[5]), .c(segB[4]), .d(segB[3]), .e(segB[2]), .f(segB[1]), .g(segB[0]));

  cyq_seg_scan_ctrl #(.DIV(7), .BLANK(3)) u_swc (
    .Clk(Clk), .Aclr(Aclr), .load(load_s), .digits(dig_s), .mask(mask_s),
    .pending(pC), .frame_start(fC),
    .COM_1(comC[0]), .COM_2(comC[1]), .COM_3(comC[2]), .COM_4(comC[3]),
    .a(segC[6]), .b(segC[5]), .c(segC[4]), .d(segC[3]), .e(segC[2]), .f(segC[1]), .g(segC[0]));

  // Glyph table {a..g} as listed for the display.
  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  // Expected commons after edge en: cnt = en mod div, slot = (en/div) mod 4.
  function automatic logic [3:0] exp_com(int en, int div, int blank, logic [3:0] msk);
    int cn = en % div;
    int s = (en / div) % 4;
    logic [3:0] one = 4'b0001;
    if (cn < blank || msk[s]) return 4'hF;
    return ~(one << s);
  endfunction

  function automatic logic [6:0] exp_seg(int en, int div, int blank, logic [15:0] dig, logic [3:0] msk);
    int cn = en % div;
    int s = (en / div) % 4;
    logic [15:0] t;
    if (cn < blank || msk[s]) return 7'd0;
    t = dig >> (4 * s);
    return glyph(t[3:0]);
  endfunction

  task automatic chk(input string tag, input int en, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed %0h expected %0h", tag, en, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    n++;
  endtask

  task automatic chk_main(input logic [15:0] dig, input logic [3:0] msk, input logic pend, input logic fs);
    chk("com", n, com0, exp_com(n, 4, 1, msk));
    chk("seg", n, seg0, exp_seg(n, 4, 1, dig, msk));
    chk("pending", n, pending, pend);
    chk("frame_start", n, frame_start, fs);
  endtask

  initial begin
    logic [15:0] ed;
    logic [3:0]  em;
    logic        ep;

    // Reset held with the clock running.
    repeat (20) @(posedge Clk);
    #1;
    chk("rst_com", 0, com0, 4'hF);
    chk("rst_seg", 0, seg0, 7'd0);
    chk("rst_pending", 0, pending, 1'b0);
    chk("rst_frame_start", 0, frame_start, 1'b0);

    // Three frames with no load: nothing may light.
    @(negedge Clk) Aclr = 1'b0;
    n = 0;
    repeat (48) begin
      step();
      chk("dark_com", n, com0, 4'hF);
      chk("dark_seg", n, seg0, 7'd0);
    end

    // Re-reset to restart edge numbering.
    Aclr = 1'b1;
    step();
    step();
    @(negedge Clk) Aclr = 1'b0;
    n = 0;

    // Loads sampled at edges 2 (1234), 32 wrap bypass (F0Ab, mask 0101),
    // 36 (1111) and 40 (2222) in one frame, 50 (5555, killed by reset).
    for (int i = 1; i <= 57; i++) begin
      step();
      if (n < 16)      begin ed = 16'h0000; em = 4'hF;    end
      else if (n < 32) begin ed = 16'h1234; em = 4'h0;    end
      else if (n < 48) begin ed = 16'hF0AB; em = 4'b0101; end
      else             begin ed = 16'h2222; em = 4'h0;    end
      ep = (n >= 2 && n <= 15) || (n >= 36 && n <= 47) || (n >= 50);
      chk_main(ed, em, ep, (n % 16) == 0);
      if (n >= 28 && n <= 56) begin
        chk("swA_com", n, comA, exp_com(n, 2, 0, 4'h0));
        chk("swA_seg", n, segA, exp_seg(n, 2, 0, 16'h8888, 4'h0));
        chk("swB_com", n, comB, exp_com(n, 2, 1, 4'h0));
        chk("swB_seg", n, segB, exp_seg(n, 2, 1, 16'h8888, 4'h0));
        chk("swC_com", n, comC, exp_com(n, 7, 3, 4'h0));
        chk("swC_seg", n, segC, exp_seg(n, 7, 3, 16'h8888, 4'h0));
      end
      load = 1'b0;
      load_s = 1'b0;
      case (n + 1)
        2:  begin load = 1'b1; digits = 16'h1234; mask = 4'h0; load_s = 1'b1; end
        32: begin load = 1'b1; digits = 16'hF0AB; mask = 4'b0101; end
        36: begin load = 1'b1; digits = 16'h1111; mask = 4'h0; end
        40: begin load = 1'b1; digits = 16'h2222; mask = 4'h0; end
        50: begin load = 1'b1; digits = 16'h5555; mask = 4'h0; end
        default: ;
      endcase
    end

    // Asynchronous reset in slot 2 with a load pending: immediate blank.
    #1;
    Aclr = 1'b1;
    #1;
    chk("arst_com", n, com0, 4'hF);
    chk("arst_seg", n, seg0, 7'd0);
    chk("arst_pending", n, pending, 1'b0);
    chk("arst_frame_start", n, frame_start, 1'b0);

    repeat (3) @(posedge Clk);
    @(negedge Clk) Aclr = 1'b0;
    n = 0;

    // Discarded load must never appear; a new load at edge 34 commits at 48.
    for (int i = 1; i <= 63; i++) begin
      step();
      if (n < 48) begin ed = 16'h0000; em = 4'hF; end
      else        begin ed = 16'h0009; em = 4'h0; end
      ep = (n >= 34 && n <= 47);
      chk_main(ed, em, ep, (n % 16) == 0);
      load = 1'b0;
      if (n + 1 == 34) begin
        load = 1'b1;
        digits = 16'h0009;
        mask = 4'h0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
